mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  CPU-side initiator for the word-organised data memory: takes lb/lbu/lh/lhu/lw/sb/sh/sw requests
//  from the datapath and drives word accesses to memory. The memory reads combinationally and writes
//  at posedge. Sub-word stores use a read-modify-write sequence. Loads are byte-lane extracted and extended.
// PARAMETERS
//  ADDR_W   32  byte-address width; memory word address = addr[ADDR_W-1:2]
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   asynchronous, active-low; clears all state
//  req_valid    in   1   request present
//  req_ready    out  1   unit idle, request accepted when req_valid&&req_ready
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 treated as word
//  req_signed   in   1   loads: 1 sign-extend, 0 zero-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, low bits used for byte/half
//  req_pc       in   32  PC of issuing instruction, forwarded to memory
//  resp_valid   out  1   one-cycle pulse, request complete
//  resp_rdata   out  32  load result, valid with resp_valid (0 for stores)
//  exc_misalign out  1   misaligned-access pulse with resp_valid (tied 0 without macro)
//  mem_addr     out  32  word-aligned address {addr[31:2],2'b00}, 0 when not accessing
//  mem_we       out  1   memory write enable
//  mem_wdata    out  32  memory write data
//  mem_rdata    in   32  memory combinational read data
//  mem_pc       out  32  captured req_pc
// BEHAVIOUR
//  - Reset (async, low): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, exc_misalign=0,
//    captured regs=0, mem_we=0, mem_addr=0. Reset mid-sequence aborts; a pending write is never issued.
//  - FSM: IDLE -> LOAD | WRITE | MERGE; MERGE -> WRITE; LOAD/WRITE -> RESP; RESP -> IDLE.
//  - IDLE: req_ready=1; on accept capture we/size/signed/addr/wdata/pc. Next state: load->LOAD,
//    store word->WRITE, store byte/half->MERGE. req_ready=0 in all other states.
//  - LOAD: mem_addr driven; extracted value registered into resp_rdata. Lane: byte=addr[1:0],
//    half=addr[1] (bits 15:0 or 31:16), little-endian (byte0 = bits 7:0).
//  - MERGE: mem_addr driven; mem_rdata merged with store data in addressed lane(s), registered.
//  - WRITE: mem_we=1 for exactly this cycle; mem_wdata=req_wdata (word) or merged word.
//  - RESP: resp_valid=1 for one cycle; stores give resp_rdata=0.
//  - Latency accept->resp_valid: load 2, sw 2, sb/sh 3 cycles; next accept one cycle after RESP.
//  - mem_we and mem_addr decode combinationally from state; only LOAD/MERGE/WRITE drive mem_addr.
//  - Without macro: misalignment ignored; half uses addr[1], word ignores addr[1:0].
// CONFIGURATION
//  MEM_MISALIGN_EXC_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE->RESP
//    directly; no memory access, mem_we stays 0, resp_rdata=0, exc_misalign=1 with resp_valid.
//  Undefined: exc_misalign tied 0, behaviour as above.
// STRUCTURE
//  - Package mem_access_pkg: size codes (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encoding.
//  - Sub-module byte_lane_unit (combinational): load extract+extend and store merge.
//  - Top holds FSM, capture registers, response register.
// TESTING
//  - Word@0x4=0x80FF1234; lb addr 0x7 -> resp_rdata 0xFFFFFF80 at accept+2; lbu -> 0x00000080.
//  - Same word; lh addr 0x6 -> 0xFFFF80FF; lhu addr 0x4 -> 0x00001234; lw 0x4 -> 0x80FF1234.
//  - Word@0x4=0x11223344; sb 0xAB addr 0x5 -> one mem_we pulse at accept+2, mem_wdata 0x1122AB44,
//    resp_valid accept+3; sh 0xBEEF addr 0x6 -> 0xBEEF3344.
//  - sw 0xDEADBEEF addr 0x8 -> mem_we at accept+1 only, mem_addr 0x8, mem_pc = req_pc.
//  - sb issued, reset low during MERGE -> mem_we never asserts, outputs at reset values, memory unchanged.
//  - lh addr 0x1: macro on -> exc_misalign+resp_valid at accept+1, no mem access;
//    macro off -> lane 0 half returned at accept+2, exc_misalign=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: access size codes and FSM state encoding shared by the memory access unit.
package mem_access_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MERGE, S_WRITE, S_RESP} state_t;
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module byte_lane_unit (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);
  import mem_access_pkg::*;
  logic [4:0]  bsh, hsh;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    bsh = {lane, 3'b000};
    hsh = {lane[1], 4'b0000};
    b = 8'(word >> bsh);
    h = 16'(word >> hsh);
    load_val = size == SZ_BYTE ? {{24{sign_ext & b[7]}}, b}
             : size == SZ_HALF ? {{16{sign_ext & h[15]}}, h} : word;
    merged = size == SZ_BYTE ? (word & ~(32'h0000_00ff << bsh)) | (32'(wdata[7:0]) << bsh)
           : size == SZ_HALF ? (word & ~(32'h0000_ffff << hsh)) | (32'(wdata[15:0]) << hsh) : wdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side word-memory initiator with read-modify-write sub-word stores.
// Define MEM_MISALIGN_EXC_EN to trap misaligned half/word accesses instead of ignoring low address bits.
module mem_access_unit import mem_access_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              exc_misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_pc
);
  state_t state, nxt;
  logic [1:0] size_q;
  logic sgn_q, exc_q, mis, is_sub, accept;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] data_q, rdata_q, pc_q, load_val, merged;
`ifdef MEM_MISALIGN_EXC_EN
  assign mis = (req_size == SZ_HALF && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign is_sub = req_size == SZ_BYTE || req_size == SZ_HALF;
  assign accept = req_valid && req_ready;
  assign req_ready = state == S_IDLE;
  assign resp_valid = state == S_RESP;
  assign resp_rdata = rdata_q;
  assign exc_misalign = resp_valid && exc_q;
  assign mem_we = state == S_WRITE;
  assign mem_addr = (state == S_LOAD || state == S_MERGE || state == S_WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? data_q : '0;
  assign mem_pc = pc_q;
  always_comb begin
    nxt = state == S_IDLE ? (!req_valid ? S_IDLE : mis ? S_RESP : !req_we ? S_LOAD : is_sub ? S_MERGE : S_WRITE)
        : state == S_MERGE ? S_WRITE
        : (state == S_LOAD || state == S_WRITE) ? S_RESP : S_IDLE;
  end
  // data_q holds the raw store data until MERGE replaces it with the merged word
  byte_lane_unit u_lane (
    .word(mem_rdata),
    .lane(addr_q[1:0]),
    .size(size_q),
    .sign_ext(sgn_q),
    .wdata(data_q),
    .load_val(load_val),
    .merged(merged)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      size_q <= '0;
      sgn_q <= 1'b0;
      exc_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      pc_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        size_q <= req_size;
        sgn_q <= req_signed;
        exc_q <= mis;
        addr_q <= req_addr;
        data_q <= req_wdata;
        rdata_q <= '0;
        pc_q <= req_pc;
      end
      if (state == S_LOAD) rdata_q <= load_val;
      if (state == S_MERGE) data_q <= merged;
    end
  end
endmodule
